// File: rtl/dist_collector_pkg.sv
// dist_collector_pkg: shared definitions for the distance collector.
//   state_e    - collector FSM states (2'd3 is unused and recovers to IDLE)
//   miss_dist  - all-ones miss sentinel for a given distance width
//   slot_off   - bit offset of object slot k in the packed distance bus
package dist_collector_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        PRESENT = 2'd2
    } state_e;

    function automatic logic [31:0] miss_dist(input int unsigned len);
        return (32'd1 << len) - 32'd1;
    endfunction

    function automatic int unsigned slot_off(input int unsigned k, input int unsigned len);
        return k * len;
    endfunction

endpackage

// File: rtl/dist_collector.sv
// dist_collector: gathers one intersection result per object for a ray and
// presents the packed distance bus to the combinational argmin stage.
//   clk, rst_n          - clock, async active-low reset
//   start               - pulse: begin a new ray (clears the bank)
//   in_valid/in_ready   - result handshake; in_id/in_hit/in_dist payload
//   out_valid/out_ready - bus handshake to the argmin stage
//   out_bus             - slot k at [k*LENGTH +: LENGTH], misses = all ones
//   out_any_hit         - at least one object hit this ray
module dist_collector
    import dist_collector_pkg::*;
#(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned LENGTH = 10
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 in_id,
    input  logic                             in_hit,
    input  logic [LENGTH-1:0]                in_dist,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [(2**WIDTH)*LENGTH-1:0]     out_bus,
    output logic                             out_any_hit
);

    localparam int unsigned NOBJ = 2**WIDTH;
    localparam int unsigned BUSW = NOBJ * LENGTH;
    localparam logic [LENGTH-1:0] MISS = LENGTH'(miss_dist(LENGTH));

    state_e              state_q, state_d;
    logic [BUSW-1:0]     bus_q, bus_d;
    logic [NOBJ-1:0]     mask_q, mask_d;
    logic                any_q, any_d;

    logic [NOBJ-1:0]     id_onehot;
    logic [LENGTH-1:0]   wr_val;
    logic                accept;

    assign in_ready    = (state_q == FILL);
    assign out_valid   = (state_q == PRESENT);
    assign out_bus     = bus_q;
    assign out_any_hit = any_q;

    // start in FILL wins over a simultaneous result, which is dropped
    assign accept    = in_valid && in_ready && !start;
    assign id_onehot = NOBJ'(1) << in_id;
    // A hit at the sentinel distance is nudged down so it never ties a miss
    assign wr_val    = !in_hit          ? MISS :
                       (in_dist == MISS) ? MISS - LENGTH'(1) : in_dist;

    always_comb begin
        state_d = state_q;
        bus_d   = bus_q;
        mask_d  = mask_q;
        any_d   = any_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bus_d   = '1;
                    mask_d  = '0;
                    any_d   = 1'b0;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (start) begin
                    bus_d  = '1;
                    mask_d = '0;
                    any_d  = 1'b0;
                end else if (accept) begin
                    for (int k = 0; k < NOBJ; k++) begin
                        if (in_id == WIDTH'(k))
                            bus_d[slot_off(k, LENGTH) +: LENGTH] = wr_val;
                    end
                    mask_d = mask_q | id_onehot;
                    any_d  = any_q | in_hit;
                    if (&mask_d) state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (out_ready && start) begin
                    bus_d   = '1;
                    mask_d  = '0;
                    any_d   = 1'b0;
                    state_d = FILL;
                end else if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bus_q   <= '1;
            mask_q  <= '0;
            any_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bus_q   <= bus_d;
            mask_q  <= mask_d;
            any_q   <= any_d;
        end
    end

endmodule

// File: doc/dist_collector.md
Name: dist_collector

Overview:
- Upstream neighbour of the nearest-object argmin stage in the ray tracer.
- Per ray, accepts one intersection result per object (object id, hit flag, distance) in any order from the intersection units.
- Assembles the results into a packed distance bus, writing a miss sentinel for every object that was not hit.
- Holds the bus stable for the combinational argmin with a valid/ready handshake until the consumer takes it.

Parameters:
- WIDTH, 3, log2 of object count (8 objects); matches the argmin stage's index width.
- LENGTH, 10, distance width in bits per object slot.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse: begin collecting a new ray.
- in_valid  input  1  intersection result present.
- in_ready  output  1  collector accepts a result this cycle.
- in_id  input  WIDTH  object index of the result.
- in_hit  input  1  1 = ray hits object.
- in_dist  input  LENGTH  hit distance; ignored when in_hit=0.
- out_valid  output  1  out_bus complete and stable.
- out_ready  input  1  downstream consumed the bus.
- out_bus  output  2**WIDTH*LENGTH  slot k at bits [k*LENGTH+LENGTH-1 -: LENGTH].
- out_any_hit  output  1  at least one object hit this ray.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - state = IDLE; in_ready = 0; out_valid = 0; out_any_hit = 0.
  - every out_bus slot = MISS_DIST (all ones); received mask = 0.
- Sentinel rules:
  - MISS_DIST = 2**LENGTH-1.
  - A hit with in_dist == MISS_DIST is stored as 2**LENGTH-2 (saturate), so a hit never ties with a miss and argmin always prefers a hit.
- IDLE:
  - in_ready = 0, out_valid = 0.
  - start=1 -> next cycle: all slots = MISS_DIST, mask = 0, out_any_hit = 0, state = FILL.
- FILL:
  - in_ready = 1.
  - Accept on in_valid & in_ready: slot[in_id] = hit ? sat(in_dist) : MISS_DIST; mask[in_id] = 1; out_any_hit |= in_hit.
  - Duplicate id: later write overwrites the slot. Mask and completion are unaffected, and out_any_hit stays sticky.
  - When mask including the current accept becomes all ones, state = PRESENT and out_valid = 1 on the following cycle.
  - Latency: final accept at edge N -> out_valid high after edge N; no bubble.
  - start=1 in FILL (with or without a simultaneous accept): start wins. Re-clear all slots and the mask, stay in FILL; the simultaneous result is discarded.
- PRESENT:
  - in_ready = 0, out_valid = 1; out_bus and out_any_hit held constant.
  - out_valid & out_ready -> IDLE, out_valid = 0 next cycle.
  - out_ready & start in the same cycle -> clear bank and go directly to FILL (back-to-back rays).
  - start without out_ready: ignored; out_valid stays 1 until taken.
- out_bus is driven straight from the slot registers, so no combinational path from inputs to out_bus.
- Reset asserted mid-operation: immediate return to reset values; any partially collected ray is lost.
- in_valid outside FILL is ignored; no error flag.

Decomposition:
- Shared package:
  - MISS_DIST function of LENGTH.
  - State enum: IDLE=2'd0, FILL=2'd1, PRESENT=2'd2; 2'd3 recovers to IDLE.
  - Slot-offset helper: slot k -> k*LENGTH.
- No sub-module: slot bank, mask and FSM live in one module.
- Mask-all-ones detect is a reduction AND; no counter.

Test Plan:
- Reset, start, then ids 0..7 in order, all hits, dist = 10*id+5 -> out_valid one cycle after id 7; slot k = 10k+5; out_any_hit = 1.
- Start, then ids 7..0 with only id 3 hit at dist 40 -> slot 3 = 40, all other slots = 1023, out_any_hit = 1.
- Start, id 2 hit dist 1023, remaining ids misses -> slot 2 = 1022, all others 1023.
- Start, 5 results, then start again, then a full set -> bus reflects only the second set; out_valid never pulses early.
- PRESENT with out_ready held 0 for 4 cycles -> bus stable, in_ready = 0; then out_ready=1 together with start -> FILL next cycle with a cleared bank.
- Duplicate id 4 (dist 50, then dist 20) among a full set -> slot 4 = 20; completion still on the 8th distinct id; rst_n pulled low mid-FILL -> all outputs at reset values asynchronously.
